c1_src_win_reader: RTL and testbench

- Read-side controller for the C1 five-bank source buffer.
- Each bank holds an identical copy of the 32x32 input image, so five image rows can be read in one cycle.
- Per output row y (0..27), the block issues one address per bank per cycle, for columns x = 0..31, using image rows y..y+4.
- Returns each 5-pixel column over a valid/ready stream to the C1 convolution window shifter.
- Frame-based: starts on a start pulse, pulses done once the last column is accepted.

---
 rtl/c1_pkg.sv | 21 ++
 rtl/c1_src_win_reader_if.sv | 39 +++
 rtl/c1_col_skid_fifo.sv | 51 +++++
 rtl/c1_src_win_reader.sv | 139 +++++++++++++
 tb/tb_c1_src_win_reader.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/c1_pkg.sv
// Shared constants and types for the C1 source-window read path.
package c1_pkg;

  localparam int unsigned IMG_W = 32;
  localparam int unsigned IMG_H = 32;
  localparam int unsigned K     = 5;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 32;
  localparam int unsigned CW    = 8;
  localparam int unsigned OUT_H = IMG_H - K + 1;

  // One FIFO entry: {col_data, col_x, row_y}
  localparam int unsigned FW = DW * K + 2 * CW;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

endpackage

// File: rtl/c1_src_win_reader_if.sv
// Bank read port plus the column stream towards the window shifter.
interface c1_src_win_reader_if;
  import c1_pkg::*;

  logic [AW*K-1:0] rd_addr_5P;
  logic [DW*K-1:0] rd_data_5P;
  logic            col_valid;
  logic            col_ready;
  logic [DW*K-1:0] col_data;
  logic [CW-1:0]   col_x;
  logic [CW-1:0]   row_y;
  logic            row_last;
  logic            frame_last;

  modport master (
    output rd_addr_5P,
    input  rd_data_5P,
    output col_valid,
    input  col_ready,
    output col_data,
    output col_x,
    output row_y,
    output row_last,
    output frame_last
  );

  modport slave (
    input  rd_addr_5P,
    output rd_data_5P,
    input  col_valid,
    output col_ready,
    input  col_data,
    input  col_x,
    input  row_y,
    input  row_last,
    input  frame_last
  );

endinterface

// File: rtl/c1_col_skid_fifo.sv
// Two-entry synchronous FIFO for the column stream; count feeds the issue credit check.
module c1_col_skid_fifo import c1_pkg::*; #(
  parameter int unsigned Width = FW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + 2'd1;
    end else if (!push_i && pop_i) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/c1_src_win_reader.sv
// Issues five-bank reads for every output column of a C1 frame and streams the
// returned 5-pixel columns downstream in x-fastest, then y, order.
module c1_src_win_reader import c1_pkg::*; #(
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  c1_src_win_reader_if.master bus
);

  state_e          state_q, state_d;
  logic [CW-1:0]   ix_q, ix_d, iy_q, iy_d;
  logic [AW-1:0]   row_base_q, row_base_d;
  logic [AW*K-1:0] rd_addr_q, lane_addr;
  logic            infl_q;
  logic [CW-1:0]   wr_x_q, wr_y_q;
  logic            busy_q, busy_d, done_q, done_d;

  logic            issue, start_ok, pop, credit_ok;
  logic [2:0]      occ;
  logic [FW-1:0]   fifo_rdata;
  logic            fifo_empty;
  logic [1:0]      fifo_count;

  assign pop      = bus.col_valid & bus.col_ready;
  // A pop this cycle frees its slot in time for the read issued now to land.
  assign occ       = {1'b0, fifo_count} + {2'b00, infl_q} - {2'b00, pop};
  assign credit_ok = (occ < 3'd2);
  assign start_ok  = (state_q == StIdle) && start && !done_q;

  // row_base tracks BASE_ADDR + iy*IMG_W; lane offsets are constants.
  always_comb begin
    lane_addr = '0;
    for (int p = 0; p < int'(K); p++) begin
      lane_addr[AW*p +: AW] = row_base_q + AW'(p * int'(IMG_W)) + AW'(ix_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    ix_d       = ix_q;
    iy_d       = iy_q;
    row_base_d = row_base_q;
    issue      = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;

    unique case (state_q)
      StIdle: begin
        // Column (0,0) is issued in the start cycle itself.
        if (start_ok) begin
          issue   = 1'b1;
          busy_d  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        issue = credit_ok;
      end
      StDrain: begin
        if (pop && bus.frame_last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      if (ix_q == CW'(IMG_W - 1)) begin
        ix_d = '0;
        if (iy_q == CW'(OUT_H - 1)) begin
          iy_d       = '0;
          row_base_d = BASE_ADDR;
          state_d    = StDrain;
        end else begin
          iy_d       = iy_q + CW'(1);
          row_base_d = row_base_q + AW'(IMG_W);
        end
      end else begin
        ix_d = ix_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ix_q       <= '0;
      iy_q       <= '0;
      row_base_q <= BASE_ADDR;
      rd_addr_q  <= {K{BASE_ADDR}};
      infl_q     <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ix_q       <= ix_d;
      iy_q       <= iy_d;
      row_base_q <= row_base_d;
      rd_addr_q  <= bus.rd_addr_5P;
      infl_q     <= issue;
      wr_x_q     <= ix_q;
      wr_y_q     <= iy_q;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rd_addr_5P = issue ? lane_addr : rd_addr_q;

  c1_col_skid_fifo #(
    .Width (FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (infl_q),
    .wdata_i ({bus.rd_data_5P, wr_x_q, wr_y_q}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {bus.col_data, bus.col_x, bus.row_y} = fifo_rdata;
  assign bus.col_valid  = !fifo_empty;
  assign bus.row_last   = (bus.col_x == CW'(IMG_W - 1));
  assign bus.frame_last = bus.row_last && (bus.row_y == CW'(OUT_H - 1));

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_c1_src_win_reader.sv
// Directed bench for c1_src_win_reader with a registered five-bank RAM model.
module tb_c1_src_win_reader;
  import c1_pkg::*;

  localparam logic [AW-1:0] Base = 32'd1024;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy, done;
  int   n_checks = 0;
  int   n_err    = 0;

  c1_src_win_reader_if bus ();

  c1_src_win_reader #(
    .BASE_ADDR (Base)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Every bank holds pixel(r,c) = r*32 + c at word Base + r*32 + c.
  logic [DW*K-1:0] bank_q;
  always @(posedge clk) begin
    for (int p = 0; p < int'(K); p++) begin
      bank_q[DW*p +: DW] <= DW'(bus.rd_addr_5P[AW*p +: AW] - Base);
    end
  end
  assign bus.rd_data_5P = bank_q;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " col_valid"}, bus.col_valid, 1'b0);
    for (int p = 0; p < int'(K); p++) begin
      chk({tag, " rd_addr"}, bus.rd_addr_5P[AW*p +: AW], Base);
    end
    chk({tag, " col_*"}, {bus.col_data, bus.col_x, bus.row_y, bus.row_last, bus.frame_last},
        '0);
  endtask

  // mode: 0 ready=1, 1 random 30% ready, 2 50-cycle freeze after first beat,
  //       3 extra start pulses at 10, 400 and in the done cycle.
  task automatic run_frame(input int mode, input int abort_row);
    int ex = 0, ey = 0, beats = 0, ndone = 0, done_cyc = -1, first = -1, frz = 0;
    bit frz_chk = 0, stall_prev = 0, rdy, st;
    logic [DW*K-1:0] exp_d;
    logic [97:0] snap = '0;

    for (int k = 0; k < 12000; k++) begin
      rdy = 1'b1;
      if (mode == 1) rdy = ($urandom_range(99) < 30);
      if (mode == 2 && beats == 1 && frz < 50) begin
        rdy = 1'b0;
        frz++;
      end
      st = (k == 0) || (mode == 3 && (k == 10 || k == 400 || k == 898));
      @(negedge clk);
      bus.col_ready = rdy;
      start = st;
      #1;

      if (k == 5) chk("busy mid-frame", busy, 1'b1);
      if (stall_prev) begin
        chk("stall hold", {bus.col_valid, bus.col_data, bus.col_x, bus.row_y, bus.row_last,
                           bus.frame_last}, {1'b1, snap});
      end
      stall_prev = bus.col_valid && !bus.col_ready;
      snap = {bus.col_data, bus.col_x, bus.row_y, bus.row_last, bus.frame_last};

      if (mode == 2 && frz == 50 && !frz_chk) begin
        frz_chk = 1;
        chk("freeze rd_addr lane0", bus.rd_addr_5P[AW-1:0], Base + 32'd2);
        chk("freeze head", {bus.col_valid, bus.col_x}, {1'b1, 8'd1});
      end

      if (done) begin
        ndone++;
        done_cyc = k;
        chk("busy low at done", busy, 1'b0);
        if (mode == 0) begin
          chk("last rd_addr lane4", bus.rd_addr_5P[AW*4 +: AW], 32'd2047);
          chk("last rd_addr lane0", bus.rd_addr_5P[AW-1:0], 32'd1919);
        end
      end

      if (bus.col_valid && bus.col_ready) begin
        for (int p = 0; p < int'(K); p++) exp_d[DW*p +: DW] = DW'((ey + p) * 32 + ex);
        if (beats == 0) first = k;
        chk($sformatf("beat %0d", beats),
            {bus.col_data, bus.col_x, bus.row_y, bus.row_last, bus.frame_last},
            {exp_d, CW'(ex), CW'(ey), ex == 31, ex == 31 && ey == 27});
        if (abort_row >= 0 && ey == abort_row) begin
          #2 rst_n = 1'b0;
          #1 chk_reset_outputs("async reset");
          chk("no done before abort", ndone, 0);
          for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j == 2) rst_n = 1'b1;
            #1 chk("no done after abort", done, 1'b0);
          end
          return;
        end
        beats++;
        if (ex == 31) begin
          ex = 0;
          ey++;
        end else begin
          ex++;
        end
      end

      if (done_cyc >= 0 && k > done_cyc) begin
        if (mode == 3) chk("start in done cycle ignored", busy, 1'b0);
        break;
      end
    end

    chk("done count", ndone, 1);
    chk("beat count", beats, 896);
    if (mode != 1) chk("first beat latency", first, 2);
    if (mode == 0 || mode == 3) chk("done latency", done_cyc, 898);
    if (mode == 2) chk("done latency with freeze", done_cyc, 948);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.col_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, -1);
    run_frame(1, -1);
    run_frame(2, -1);
    run_frame(3, -1);
    run_frame(0, -1);
    run_frame(0, 13);
    repeat (2) @(negedge clk);
    run_frame(0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
